mem_arbiter_burst: RTL
======================

Name: mem_arbiter_burst

Overview:
Parametrised N-client line-memory arbiter merged with a cacheline burst adaptor. Up to NUM_CLIENTS caches (I-cache, D-cache, later prefetcher/L2 ports) each issue whole-line reads or writes. The block grants one client at a time by round-robin and converts the LINE_WIDTH line into LINE_WIDTH/BURST_WIDTH beats on the physical memory bus. It replaces the fixed two-client arbiter plus adaptor pair in the memory subsystem top level.

Parameters:
NUM_CLIENTS, 2, number of requesting caches (>=1).
ADDR_WIDTH, 32, address width.
LINE_WIDTH, 256, cacheline width in bits.
BURST_WIDTH, 64, physical memory beat width; LINE_WIDTH must be an integer multiple of it.
BEATS, LINE_WIDTH/BURST_WIDTH (derived, not overridable), beats per line.

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
client_read  in  NUM_CLIENTS  per-client line read request; client holds it until its client_resp
client_write  in  NUM_CLIENTS  per-client line write request; client holds it until its client_resp
client_address  in  NUM_CLIENTS*ADDR_WIDTH  packed per-client line addresses; slice i is client i
client_wdata  in  NUM_CLIENTS*LINE_WIDTH  packed per-client write lines
client_resp  out  NUM_CLIENTS  one-cycle completion pulse, one-hot
client_rdata  out  LINE_WIDTH  assembled read line, shared by all clients
pmem_address  out  ADDR_WIDTH  line-aligned address of the granted transaction
pmem_read  out  1  memory read strobe
pmem_write  out  1  memory write strobe
pmem_wdata  out  BURST_WIDTH  current write beat
pmem_rdata  in  BURST_WIDTH  current read beat
pmem_resp  in  1  beat accepted or valid

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; rr pointer=0; beat counter=0; every output 0, including client_rdata. In-flight burst is abandoned with no client_resp.
- States: IDLE, READ, WRITE, DONE.
- IDLE: a client is pending if client_read[i] or client_write[i]. Grant the first pending client from rr pointer upward, mod NUM_CLIENTS. Register gnt index, address with low log2(LINE_WIDTH/8) bits forced to 0, and the write line if writing.
  - If the granted client has write=1, go to WRITE, even when read is also 1. Otherwise go to READ.
  - No pending client: stay in IDLE.
- READ: pmem_read=1, pmem_address held. On each cycle with pmem_resp=1, store pmem_rdata into line slice [beat*BURST_WIDTH +: BURST_WIDTH] and increment beat. Beats may arrive with gaps.
  - When the beat BEATS-1 is accepted, deassert pmem_read next cycle, clear beat, and go to DONE.
- WRITE: pmem_write=1; pmem_wdata = registered line slice for the current beat. The beat counter advances on each pmem_resp. After the beat BEATS-1 is accepted, go to DONE.
- DONE: client_resp[gnt]=1 for exactly this one cycle; pmem_read=pmem_write=0. Set rr pointer=(gnt+1) mod NUM_CLIENTS, then go to IDLE.
- client_rdata: updated only by READ completion. Holds the last read line stable through DONE and afterwards until the next read completes. A WRITE does not change it.
- Latency:
  - Request seen in IDLE at cycle 0 gives pmem strobe in cycle 1.
  - With pmem_resp high from cycle 1, the last beat is accepted in cycle BEATS.
  - DONE/client_resp is in cycle BEATS+1 (cycle 5 for the defaults).
  - Next arbitration happens in cycle BEATS+2.
- Client request or address changing mid-transaction is ignored; the registered copy is used.
- pmem_resp outside READ/WRITE is ignored.
- One transaction in flight; no pipelining between clients.
- NUM_CLIENTS=1: the rr pointer stays 0.

Test Plan:
- Single read, client 0, addr 0x0000_1234, 4 beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> pmem_address=0x0000_1220; client_rdata={0x44..,0x33..,0x22..,0x11..}; client_resp=2'b01 in cycle 5 only.
- Single write, client 1, line 0xAAAA_..._DDDD -> pmem_wdata beats go low slice first; client_resp=2'b10 after the 4th pmem_resp; client_rdata unchanged.
- Both clients request continuously (NUM_CLIENTS=2) -> grants alternate 0,1,0,1; no client gets two consecutive grants while the other is pending.
- pmem_resp with gaps (1,0,0,1,1,0,1) on a read -> beats land in the correct slices; client_resp follows the 4th accepted beat.
- Read and write both asserted by one client -> write burst first, then a separate read transaction, each with its own resp pulse.
- rst=0 asserted mid-READ after 2 beats -> all outputs 0 immediately; no client_resp; the next request starts at beat 0 with pointer 0.

Source files
------------

// File: rtl/mem_arbiter_burst.sv
// Round-robin N-client cacheline arbiter that moves each granted line
// over the physical memory bus as LINE_WIDTH/BURST_WIDTH beats.
module mem_arbiter_burst #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLIENTS-1:0]            client_read,
  input  logic [NUM_CLIENTS-1:0]            client_write,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_address,
  input  logic [NUM_CLIENTS*LINE_WIDTH-1:0] client_wdata,
  output logic [NUM_CLIENTS-1:0]            client_resp,
  output logic [LINE_WIDTH-1:0]             client_rdata,
  output logic [ADDR_WIDTH-1:0]             pmem_address,
  output logic                              pmem_read,
  output logic                              pmem_write,
  output logic [BURST_WIDTH-1:0]            pmem_wdata,
  input  logic [BURST_WIDTH-1:0]            pmem_rdata,
  input  logic                              pmem_resp
);

  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CW    = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF   = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] AMASK = {ADDR_WIDTH{1'b1}} << OFF;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          rr, gnt, pick;
  logic                   found, pick_wr, last;
  logic [BCW-1:0]         beat;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LINE_WIDTH-1:0]  line, line_nx;

  // First pending client at or after the rr pointer, wrapping mod NUM_CLIENTS.
  always_comb begin
    logic [CW:0] s;
    found = 1'b0;
    pick  = rr;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      s = {1'b0, rr} + (CW+1)'(k);
      if (s >= (CW+1)'(NUM_CLIENTS)) s = s - (CW+1)'(NUM_CLIENTS);
      if (!found && (client_read[s[CW-1:0]] || client_write[s[CW-1:0]])) begin
        found = 1'b1;
        pick  = s[CW-1:0];
      end
    end
  end

  assign pick_wr = client_write[pick];
  assign last    = (beat == BCW'(BEATS-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:        if (found) state_nx = pick_wr ? WRITE : READ;
      READ, WRITE: if (pmem_resp && last) state_nx = DONE;
      DONE:        state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  // Read beats assemble into the same buffer that holds the write line.
  always_comb begin
    line_nx = line;
    line_nx[int'(beat)*BURST_WIDTH +: BURST_WIDTH] = pmem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr           <= '0;
      gnt          <= '0;
      beat         <= '0;
      addr_q       <= '0;
      line         <= '0;
      client_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: if (found) begin
          gnt    <= pick;
          beat   <= '0;
          addr_q <= client_address[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH] & AMASK;
          if (pick_wr) line <= client_wdata[int'(pick)*LINE_WIDTH +: LINE_WIDTH];
        end
        READ: if (pmem_resp) begin
          line <= line_nx;
          if (last) begin
            client_rdata <= line_nx;
            beat         <= '0;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        WRITE: if (pmem_resp) beat <= last ? '0 : beat + 1'b1;
        DONE:  rr <= (gnt == CW'(NUM_CLIENTS-1)) ? '0 : gnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    client_resp = '0;
    if (state == DONE) client_resp[gnt] = 1'b1;
  end

  assign pmem_read    = (state == READ);
  assign pmem_write   = (state == WRITE);
  assign pmem_address = addr_q;
  assign pmem_wdata   = (state == WRITE) ? line[int'(beat)*BURST_WIDTH +: BURST_WIDTH] : '0;

endmodule
